// File: rtl/range_bin_overlap_reader.sv
// Splits one shot of FIFO words into a noise frame followed by 50%-overlapped range frames.
// The overlapped half is replayed from a local half-frame buffer, so each FIFO word is popped once.
module range_bin_overlap_reader #(
  parameter int DATA_W   = 32,
  parameter int MAX_HALF = 256,
  parameter int BIN_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       nPointsPerBin,
  input  logic [BIN_W-1:0]  nRangeBins,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic [BIN_W-1:0]  out_bin,
  output logic              busy,
  output logic              done
);

  localparam int AW = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_NOISE, S_FIRST_A, S_FRESH_B, S_REPLAY_A, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [14:0]        wc_q, wc_d;
  logic [14:0]        w_q, w_d;
  logic [13:0]        h_q, h_d;
  logic [BIN_W-1:0]   nb_q, nb_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_first_q, out_first_d;
  logic               out_last_q, out_last_d;
  logic [BIN_W-1:0]   out_bin_q, out_bin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DATA_W-1:0]  buf_mem [MAX_HALF];
  logic               buf_we;

  logic               fresh, replay, avail, adv, load, at_end;
  logic [14:0]        limit;
  logic [DATA_W-1:0]  src_data;

  assign fresh    = (state_q == S_NOISE) || (state_q == S_FIRST_A) || (state_q == S_FRESH_B);
  assign replay   = (state_q == S_REPLAY_A);
  assign avail    = fresh ? !fifo_empty : replay;
  assign adv      = !out_valid_q || out_ready;
  assign load     = adv && avail;
  assign limit    = (state_q == S_NOISE) ? w_q : {1'b0, h_q};
  assign at_end   = (wc_q == limit - 15'd1);
  assign src_data = replay ? buf_mem[wc_q[AW-1:0]] : fifo_dout;

  assign fifo_rd_en = adv && fresh && !fifo_empty;
  assign buf_we     = load && (state_q == S_FRESH_B);

  always_comb begin
    state_d     = state_q;
    wc_d        = wc_q;
    w_d         = w_q;
    h_d         = h_q;
    nb_d        = nb_q;
    bin_d       = bin_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_bin_d   = out_bin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      // A start coinciding with the done pulse is deliberately dropped.
      S_IDLE: begin
        if (start && !done_q) begin
          w_d     = nPointsPerBin[15:1];
          h_d     = nPointsPerBin[15:2];
          nb_d    = nRangeBins;
          bin_d   = '0;
          wc_d    = '0;
          busy_d  = 1'b1;
          state_d = S_NOISE;
        end
      end
      S_DONE: begin
        if (!out_valid_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    if (load) begin
      out_data_d  = src_data;
      out_valid_d = 1'b1;
      out_bin_d   = bin_q;
      out_first_d = (wc_q == 15'd0) &&
                    ((state_q == S_NOISE) || (state_q == S_FIRST_A) || (state_q == S_REPLAY_A));
      out_last_d  = at_end && ((state_q == S_NOISE) || (state_q == S_FRESH_B));
      wc_d        = wc_q + 15'd1;
      if (at_end) begin
        wc_d = '0;
        case (state_q)
          S_NOISE: begin
            if (nb_q == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FIRST_A;
              bin_d   = BIN_W'(1);
            end
          end
          S_FIRST_A:  state_d = S_FRESH_B;
          S_FRESH_B: begin
            if (bin_q == nb_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_REPLAY_A;
              bin_d   = bin_q + BIN_W'(1);
            end
          end
          S_REPLAY_A: state_d = S_FRESH_B;
          default: ;
        endcase
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wc_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      nb_q        <= '0;
      bin_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bin_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wc_q        <= wc_d;
      w_q         <= w_d;
      h_q         <= h_d;
      nb_q        <= nb_d;
      bin_q       <= bin_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_bin_q   <= out_bin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Replay reads finish before FRESH_B rewrites the same addresses, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[wc_q[AW-1:0]] <= fifo_dout;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_bin   = out_bin_q;
  assign busy      = busy_q;
  assign done      = done_q;

  a_param_range: assert property (@(posedge clk) disable iff (rst)
    (start && state_q == S_IDLE && !done_q) |->
      (nPointsPerBin >= 16'd8 && nPointsPerBin[1:0] == 2'b00 &&
       32'(nPointsPerBin[15:2]) <= MAX_HALF));

endmodule

// File: tb/tb_range_bin_overlap_reader.sv
// Directed bench for range_bin_overlap_reader: FIFO model, expected-frame model and transfer monitor.
// Covers plain shots, backpressure, FIFO starvation, mid-shot start/reset and full replay depth.
module tb_range_bin_overlap_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] nPointsPerBin = 16'd16;
  logic [7:0]  nRangeBins = 8'd0;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_first;
  logic        out_last;
  logic [7:0]  out_bin;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  range_bin_overlap_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .nPointsPerBin(nPointsPerBin), .nRangeBins(nRangeBins),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .out_bin(out_bin),
    .busy(busy), .done(done)
  );

  // FIFO model (first-word-fall-through)
  logic [31:0] fifo_mem [0:4095];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  int  pops = 0;
  int  pop_empty = 0;
  bit  force_empty = 1'b0;
  bit  flush = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || force_empty;
  assign fifo_dout  = fifo_mem[rd_ptr & 4095];

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
      if (fifo_empty) pop_empty <= pop_empty + 1;
    end
  end

  // Expected frame stream
  logic [31:0] exp_data  [0:2047];
  bit          exp_first [0:2047];
  bit          exp_last  [0:2047];
  logic [7:0]  exp_bin   [0:2047];
  int exp_n = 0;
  int exp_pops = 0;

  int checks = 0;
  int failures = 0;
  int rx_n = 0, rx_base = 0, done_cnt = 0;
  int pops_base = 0, pe_base = 0, dc_base = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input bit f, input bit l, input int b);
    exp_data[exp_n]  = d;
    exp_first[exp_n] = f;
    exp_last[exp_n]  = l;
    exp_bin[exp_n]   = 8'(b);
    exp_n++;
  endtask

  task automatic build_expected(input int npts, input int nb);
    int w, h, p;
    logic [31:0] half [0:255];
    w = npts / 2;
    h = npts / 4;
    p = rd_ptr;
    exp_n = 0;
    for (int i = 0; i < w; i++) push(fifo_mem[(p + i) & 4095], i == 0, i == w - 1, 0);
    p += w;
    if (nb > 0) begin
      for (int i = 0; i < w; i++) push(fifo_mem[(p + i) & 4095], i == 0, i == w - 1, 1);
      for (int i = 0; i < h; i++) half[i] = fifo_mem[(p + h + i) & 4095];
      p += w;
      for (int b = 2; b <= nb; b++) begin
        for (int i = 0; i < h; i++) push(half[i], i == 0, 1'b0, b);
        for (int i = 0; i < h; i++) begin
          push(fifo_mem[(p + i) & 4095], 1'b0, i == h - 1, b);
          half[i] = fifo_mem[(p + i) & 4095];
        end
        p += h;
      end
    end
    exp_pops = p - rd_ptr;
  endtask

  task automatic fill(input int tag, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr & 4095] = (32'(tag) << 24) | 32'(i);
      wr_ptr++;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rd_en"}, fifo_rd_en, 0);
    check({pfx, "_valid"}, out_valid, 0);
    check({pfx, "_data"},  out_data, 0);
    check({pfx, "_first"}, out_first, 0);
    check({pfx, "_last"},  out_last, 0);
    check({pfx, "_bin"},   out_bin, 0);
    check({pfx, "_busy"},  busy, 0);
    check({pfx, "_done"},  done, 0);
  endtask

  // Transfer monitor, sampled on the falling edge
  initial begin
    bit prev_hold;
    logic [31:0] prev_data;
    int idx;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (prev_hold) check("hold_stable", {out_valid, out_data}, {1'b1, prev_data});
      prev_hold = out_valid && !out_ready && !rst;
      prev_data = out_data;
      if (out_valid && out_ready) begin
        idx = rx_n - rx_base;
        if (idx < exp_n) begin
          check($sformatf("data[%0d]", idx), out_data, exp_data[idx]);
          check($sformatf("flags[%0d]", idx), {out_first, out_last, out_bin},
                {exp_first[idx], exp_last[idx], exp_bin[idx]});
        end else begin
          check("overrun_idx", idx, exp_n - 1);
        end
        rx_n++;
      end
      if (done) begin
        done_cnt++;
        check("done_while_valid", out_valid, 0);
      end
    end
  end

  task automatic pulse_start(input int npts, input int nb);
    @(posedge clk); #1;
    nPointsPerBin = 16'(npts);
    nRangeBins    = 8'(nb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nPointsPerBin = 16'd12;
    nRangeBins    = 8'd7;
    check("busy_after_start", busy, 1);
  endtask

  task automatic prepare(input int npts, input int nb, input int tag);
    int n;
    n = npts / 2 + ((nb > 0) ? (npts / 2 + (nb - 1) * (npts / 4)) : 0);
    fill(tag, n);
    build_expected(npts, nb);
    rx_base   = rx_n;
    pops_base = pops;
    pe_base   = pop_empty;
    dc_base   = done_cnt;
  endtask

  // mode 0: ready always; 1: ready 1-of-3 cycles; 2: FIFO starved 5 cycles in bin2 FRESH_B
  task automatic run_shot(input int npts, input int nb, input int tag, input int mode);
    bit seen;
    int cyc, left, budget;
    prepare(npts, nb, tag);
    pulse_start(npts, nb);
    seen = 1'b0;
    cyc = 0;
    left = 5;
    budget = 6 * exp_n + 100;
    while (!seen && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
      out_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      if (mode == 2) begin
        if (force_empty) begin
          left--;
          if (left == 0) force_empty = 1'b0;
        end else if (left == 5 && (pops - pops_base) == 18) begin
          force_empty = 1'b1;
        end
      end
    end
    out_ready = 1'b1;
    force_empty = 1'b0;
    @(negedge clk);
    check("done_seen", seen, 1);
    check("words_out", rx_n - rx_base, exp_n);
    check("fifo_pops", pops - pops_base, exp_pops);
    check("pop_on_empty", pop_empty - pe_base, 0);
    check("done_pulses", done_cnt - dc_base, 1);
    check("busy_end", busy, 0);
    if (mode == 2) check("starve_window", left, 0);
    $display("shot npts=%0d bins=%0d mode=%0d words=%0d pops=%0d", npts, nb, mode,
             rx_n - rx_base, pops - pops_base);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    run_shot(16, 0, 0, 0);
    run_shot(16, 3, 0, 0);
    run_shot(16, 3, 1, 1);
    run_shot(16, 3, 2, 2);

    // Mid-shot start is ignored, then reset during bin2
    prepare(16, 3, 5);
    pulse_start(16, 3);
    cyc = 0;
    while ((rx_n - rx_base) < 17 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 6);
    end
    start = 1'b0;
    check("reach_bin2", (rx_n - rx_base) >= 17, 1);
    check("busy_mid", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushed", fifo_empty, 1);
    $display("shot npts=16 bins=3 reset after %0d words", rx_n - rx_base);
    run_shot(16, 3, 6, 0);

    run_shot(1024, 2, 7, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
